red_pitaya_trig_sched: RTL and testbench



---
 rtl/red_pitaya_trig_sched_pkg.sv | 14 +
 rtl/red_pitaya_trig_pulse.sv | 43 ++++
 rtl/red_pitaya_trig_sched.sv | 160 ++++++++++++++++
 tb/tb_red_pitaya_trig_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_trig_sched_pkg.sv
// Shared encodings for the trigger scheduler: start-source selection and
// FSM state codes.
package red_pitaya_trig_sched_pkg;

  localparam logic [1:0] SRC_SW    = 2'd0;
  localparam logic [1:0] SRC_EXT_R = 2'd1;
  localparam logic [1:0] SRC_EXT_F = 2'd2;
  localparam logic [1:0] SRC_FREE  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/red_pitaya_trig_pulse.sv
// Loadable down-counter pulse stretcher. A fire (re)loads the counter with
// max(len, 1) and the registered level stays high while the count is non-zero.
module red_pitaya_trig_pulse #(
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          fire,
  input  logic [LW-1:0] len,
  output logic          level
);

  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nxt;

  function automatic logic [LW-1:0] floor_one(input logic [LW-1:0] v);
    return (v == '0) ? LW'(1) : v;
  endfunction

  // Next count: clear dominates, then reload on fire, else count down to zero.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (fire)
      cnt_nxt = floor_one(len);
    else if (cnt != '0)
      cnt_nxt = cnt - LW'(1);
  end

  // Counter and registered output level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/red_pitaya_trig_sched.sv
// Trigger scheduler: on a start event it issues nburst periods of trig_a /
// trig_b pulses, B offset from A by dly_b clocks, each pulse stretched to the
// programmed width. Configuration is shadowed at start.
module red_pitaya_trig_sched
  import red_pitaya_trig_sched_pkg::*;
#(
  parameter int PW = 32,
  parameter int NW = 16,
  parameter int LW = 16
) (
  input  logic          dac_clk_i,
  input  logic          dac_rstn_i,
  input  logic          cfg_en_i,
  input  logic [1:0]    cfg_src_i,
  input  logic [PW-1:0] cfg_period_i,
  input  logic [NW-1:0] cfg_nburst_i,
  input  logic [PW-1:0] cfg_dly_b_i,
  input  logic [LW-1:0] cfg_pulse_i,
  input  logic          sw_trig_i,
  input  logic          ext_trig_i,
  output logic          trig_a_o,
  output logic          trig_b_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] burst_cnt_o
);

  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [PW-1:0] per_s;
  logic [PW-1:0] dly_s;
  logic [NW-1:0] nb_s;
  logic [LW-1:0] pls_s;
  logic [NW-1:0] burst_cnt;
  logic [NW-1:0] cnt_nxt;
  logic          sync1, sync2, hist;
  logic          edge_r, edge_f;
  logic          start;
  logic          run;
  logic          fire_a, fire_b;
  logic          last;
  logic          clr;

  function automatic logic [PW-1:0] floor_one(input logic [PW-1:0] v);
    return (v == '0) ? PW'(1) : v;
  endfunction

  // Two-flop synchroniser plus history flop for external edge detection.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= ext_trig_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_r = sync2 & ~hist;
  assign edge_f = ~sync2 & hist;

  // Start event according to the selected source.
  always_comb begin
    start = 1'b0;
    case (cfg_src_i)
      SRC_SW:    start = sw_trig_i;
      SRC_EXT_R: start = edge_r;
      SRC_EXT_F: start = edge_f;
      SRC_FREE:  start = 1'b1;
      default:   start = 1'b0;
    endcase
  end

  assign run     = (state == ST_RUN);
  assign fire_a  = run & cfg_en_i & (phase == '0);
  assign fire_b  = run & cfg_en_i & (phase == dly_s);
  // Count including this cycle's A fire, so period 1 terminates on time.
  assign cnt_nxt = burst_cnt + {{(NW-1){1'b0}}, fire_a};
  assign last    = run & (nb_s != '0) & (phase == (per_s - PW'(1))) & (cnt_nxt == nb_s);
  assign clr     = ~cfg_en_i;

  // Scheduler FSM, phase counter, burst counter and shadow configuration.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state     <= ST_IDLE;
      phase     <= '0;
      per_s     <= '0;
      dly_s     <= '0;
      nb_s      <= '0;
      pls_s     <= '0;
      burst_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else if (!cfg_en_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start) begin
            per_s     <= floor_one(cfg_period_i);
            dly_s     <= cfg_dly_b_i;
            nb_s      <= cfg_nburst_i;
            pls_s     <= cfg_pulse_i;
            phase     <= '0;
            burst_cnt <= '0;
            busy_o    <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          burst_cnt <= cnt_nxt;
          if (last) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (phase == (per_s - PW'(1))) begin
            phase <= '0;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  assign burst_cnt_o = burst_cnt;

  red_pitaya_trig_pulse #(.LW(LW)) u_pulse_a (
    .clk   (dac_clk_i),
    .rst_n (dac_rstn_i),
    .clr   (clr),
    .fire  (fire_a),
    .len   (pls_s),
    .level (trig_a_o)
  );

  red_pitaya_trig_pulse #(.LW(LW)) u_pulse_b (
    .clk   (dac_clk_i),
    .rst_n (dac_rstn_i),
    .clr   (clr),
    .fire  (fire_b),
    .len   (pls_s),
    .level (trig_b_o)
  );

endmodule

// File: tb/tb_red_pitaya_trig_sched.sv
// Scoreboard bench for the trigger scheduler: stimulus queues per-cycle
// expected output vectors and expected done events; a monitor on the falling
// clock edge pops and compares them against the DUT.
module tb_red_pitaya_trig_sched;

  localparam int PW = 32;
  localparam int NW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_en = 1'b0;
  logic [1:0]    cfg_src = 2'd0;
  logic [PW-1:0] cfg_period = '0;
  logic [NW-1:0] cfg_nburst = '0;
  logic [PW-1:0] cfg_dly_b = '0;
  logic [LW-1:0] cfg_pulse = '0;
  logic          sw_trig = 1'b0;
  logic          ext_trig = 1'b0;
  logic          trig_a, trig_b, busy, done;
  logic [NW-1:0] burst_cnt;

  red_pitaya_trig_sched #(.PW(PW), .NW(NW), .LW(LW)) dut (
    .dac_clk_i    (clk),
    .dac_rstn_i   (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_src_i    (cfg_src),
    .cfg_period_i (cfg_period),
    .cfg_nburst_i (cfg_nburst),
    .cfg_dly_b_i  (cfg_dly_b),
    .cfg_pulse_i  (cfg_pulse),
    .sw_trig_i    (sw_trig),
    .ext_trig_i   (ext_trig),
    .trig_a_o     (trig_a),
    .trig_b_o     (trig_b),
    .busy_o       (busy),
    .done_o       (done),
    .burst_cnt_o  (burst_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    int         cnt;
    string      name;
  } exp_t;

  typedef struct {
    int cyc;
    int cnt;
  } done_t;

  exp_t  q[$];
  done_t dq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(int c, bit a, bit b, bit bz, bit dn, int cnt, string name);
    exp_t e;
    e.cyc  = c;
    e.val  = {a, b, bz, dn};
    e.cnt  = cnt;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic push_done(int c, int cnt);
    done_t d;
    d.cyc = c;
    d.cnt = cnt;
    dq.push_back(d);
  endtask

  // High if c lies in any of n windows of length len starting s, s+per, ...
  function automatic bit win(int c, int s, int len, int per, int n);
    for (int k = 0; k < n; k++)
      if (c >= s + k * per && c < s + k * per + len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(logic [1:0] src, int per, int nb, int dly, int pls);
    cfg_src    = src;
    cfg_period = PW'(per);
    cfg_nburst = NW'(nb);
    cfg_dly_b  = PW'(dly);
    cfg_pulse  = LW'(pls);
  endtask

  task automatic sw_go(int t);
    cfg_en  = 1'b1;
    sw_trig = 1'b1;
    wait_cyc(t);
    sw_trig = 1'b0;
  endtask

  // Monitor: per-cycle vector checks and done-event checks.
  exp_t       me;
  done_t      md;
  logic [3:0] obs;
  always @(negedge clk) begin
    obs = {trig_a, trig_b, busy, done};
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      checks++;
      if (me.cyc != cyc) begin
        errors++;
        $display("FAIL %s: entry for cycle %0d reached at cycle %0d", me.name, me.cyc, cyc);
      end else if (obs != me.val || (me.cnt >= 0 && int'(burst_cnt) != me.cnt)) begin
        errors++;
        $display("FAIL %s cyc %0d: a/b/busy/done=%b cnt=%0d, required %b cnt=%0d",
                 me.name, cyc, obs, burst_cnt, me.val, me.cnt);
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc %0d: done_o high, none required", cyc);
      end else begin
        md = dq.pop_front();
        if (md.cyc != cyc || int'(burst_cnt) != md.cnt) begin
          errors++;
          $display("FAIL done_event: at cyc %0d cnt=%0d, required cyc %0d cnt=%0d",
                   cyc, burst_cnt, md.cyc, md.cnt);
        end
      end
    end
  end

  int t, s;

  initial begin
    // Reset state
    for (int c = 1; c <= 4; c++) push(c, 0, 0, 0, 0, 0, "reset");
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);

    // Software start, period 10, 3 periods, B at +4, 2-clock pulses
    cfg(2'd0, 10, 3, 4, 2);
    t = cyc + 1;
    for (int c = t - 1; c <= t + 32; c++)
      push(c, win(c, t + 1, 2, 10, 3), win(c, t + 5, 2, 10, 3),
           (c >= t && c <= t + 29), (c == t + 30),
           (c == t + 1) ? 1 : (c == t + 11) ? 2 : (c >= t + 30) ? 3 : -1, "sw_burst");
    push_done(t + 30, 3);
    sw_go(t);
    wait_cyc(t + 34);

    // External rising edge, src 1
    cfg(2'd1, 10, 1, 4, 2);
    t = cyc + 1;
    for (int c = t; c <= t + 6; c++)
      push(c, win(c, t + 3, 2, 10, 1), 0, (c >= t + 2), 0, -1, "ext_rise");
    push_done(t + 12, 1);
    #3 ext_trig = 1'b1;
    wait_cyc(t + 14);
    // Falling edge with src 1: no start
    t = cyc + 1;
    for (int c = t; c <= t + 8; c++) push(c, 0, 0, 0, 0, -1, "ext_rise_ignores_fall");
    #3 ext_trig = 1'b0;
    wait_cyc(t + 9);
    // src 2: rising edge ignored, falling edge starts
    cfg(2'd2, 10, 1, 4, 2);
    t = cyc + 1;
    for (int c = t; c <= t + 8; c++) push(c, 0, 0, 0, 0, -1, "ext_fall_ignores_rise");
    #3 ext_trig = 1'b1;
    wait_cyc(t + 9);
    t = cyc + 1;
    for (int c = t; c <= t + 6; c++)
      push(c, win(c, t + 3, 2, 10, 1), 0, (c >= t + 2), 0, -1, "ext_fall");
    push_done(t + 12, 1);
    #3 ext_trig = 1'b0;
    wait_cyc(t + 14);

    // Free-running, period 4, 2 periods, B at +1, 1-clock pulses
    cfg_en = 1'b0;
    wait_cyc(cyc + 2);
    cfg(2'd3, 4, 2, 1, 1);
    s = cyc + 1;
    for (int c = s - 1; c <= s + 31; c++)
      push(c,
           (c <= s + 29) && (win(c, s + 1, 1, 4, 2) || win(c, s + 11, 1, 4, 2) || win(c, s + 21, 1, 4, 2)),
           (c <= s + 29) && (win(c, s + 2, 1, 4, 2) || win(c, s + 12, 1, 4, 2) || win(c, s + 22, 1, 4, 2)),
           (c >= s) && (c <= s + 29) && ((c - s) % 10 != 8) && ((c - s) % 10 != 9),
           (c >= s) && (c <= s + 29) && ((c - s) % 10 == 8), -1, "free_run");
    push_done(s + 8, 2);
    push_done(s + 18, 2);
    push_done(s + 28, 2);
    cfg_en = 1'b1;
    wait_cyc(s + 29);
    cfg_en = 1'b0;
    wait_cyc(s + 33);

    // period 0 -> A (and B, dly 0) high continuously; then disable
    cfg(2'd0, 0, 0, 0, 1);
    t = cyc + 1;
    for (int c = t; c <= t + 12; c++)
      push(c, (c >= t + 1 && c <= t + 10), (c >= t + 1 && c <= t + 10),
           (c >= t && c <= t + 10), 0, -1, "period_zero");
    sw_go(t);
    wait_cyc(t + 10);
    cfg_en = 1'b0;
    wait_cyc(t + 13);

    // pulse 0 -> 1-clock pulses
    cfg(2'd0, 10, 1, 3, 0);
    t = cyc + 1;
    for (int c = t; c <= t + 11; c++)
      push(c, (c == t + 1), (c == t + 4), (c >= t && c <= t + 9), (c == t + 10),
           (c >= t + 10) ? 1 : -1, "pulse_zero");
    push_done(t + 10, 1);
    sw_go(t);
    wait_cyc(t + 12);

    // dly_b beyond period -> B never fires
    cfg(2'd0, 10, 2, 12, 1);
    t = cyc + 1;
    for (int c = t; c <= t + 21; c++)
      push(c, (c == t + 1 || c == t + 11), 0, (c >= t && c <= t + 19), (c == t + 20),
           -1, "dly_beyond_period");
    push_done(t + 20, 2);
    sw_go(t);
    wait_cyc(t + 22);

    // pulse longer than period -> A held high for the whole burst
    cfg(2'd0, 10, 2, 12, 20);
    t = cyc + 1;
    for (int c = t; c <= t + 20; c++)
      push(c, (c >= t + 1), 0, (c >= t && c <= t + 19), (c == t + 20), -1, "pulse_over_period");
    push_done(t + 20, 2);
    sw_go(t);
    wait_cyc(t + 21);
    cfg_en = 1'b0;
    push(t + 22, 0, 0, 0, 0, -1, "disable_clears_pulse");
    wait_cyc(t + 24);

    // Endless, period 7, disable at phase 5 of the third period
    cfg(2'd0, 7, 0, 2, 6);
    t = cyc + 1;
    for (int c = t; c <= t + 22; c++)
      push(c, (c <= t + 19) && win(c, t + 1, 6, 7, 3), (c <= t + 19) && win(c, t + 3, 6, 7, 3),
           (c >= t && c <= t + 19), 0,
           (c == t + 2) ? 1 : (c == t + 19) ? 3 : -1, "endless_disable");
    sw_go(t);
    wait_cyc(t + 3);
    cfg_period = PW'(3);
    wait_cyc(t + 19);
    cfg_en = 1'b0;
    wait_cyc(t + 24);

    // Asynchronous reset mid-burst, then restart
    cfg(2'd0, 10, 3, 0, 5);
    t = cyc + 1;
    push(t + 1, 1, 1, 1, 0, 1, "pre_reset");
    for (int c = t + 2; c <= t + 4; c++) push(c, 0, 0, 0, 0, 0, "async_reset");
    sw_go(t);
    wait_cyc(t + 2);
    rst_n = 1'b0;
    wait_cyc(t + 4);
    rst_n = 1'b1;
    t = cyc + 1;
    for (int c = t; c <= t + 3; c++)
      push(c, (c >= t + 1), (c >= t + 1), 1, 0, (c == t + 1) ? 1 : -1, "restart");
    push_done(t + 30, 3);
    sw_go(t);
    wait_cyc(t + 33);

    checks++;
    if (q.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d vector and %0d done entries pending, required 0", q.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
